// File: rtl/core_pkg.sv
// Shared definitions for the write-back completion queue: extend-select
// encodings and the per-entry control word.
package core_pkg;

   localparam logic [2:0] WB_SX_BP  = 3'd0;
   localparam logic [2:0] WB_SX_UB  = 3'd1;
   localparam logic [2:0] WB_SX_B   = 3'd2;
   localparam logic [2:0] WB_SX_UH  = 3'd3;
   localparam logic [2:0] WB_SX_H   = 3'd4;
   localparam logic [2:0] WB_SX_IMM = 3'd5;
   localparam logic [2:0] WB_SX_PC  = 3'd6;

   // Fixed-width control part of a queue entry; rd, addr_lo and value are
   // held in parameter-sized arrays next to it.
   typedef struct packed {
      logic       we;
      logic [2:0] sx_op;
      logic       is_load;
      logic       rdy;
   } wb_ctl_t;

endpackage

// File: rtl/core_wb_ext.sv
// Combinational align and sign/zero extension of a write-back value.
module core_wb_ext
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]              val_i,
   input  logic [2:0]                   sx_op_i,
   input  logic [$clog2(XLEN/8)-1:0]    addr_lo_i,
   output logic [XLEN-1:0]              ext_o
);

   localparam int ALW = $clog2(XLEN/8);

   logic [ALW-1:0]  half_lo;
   logic [XLEN-1:0] sh_b;
   logic [XLEN-1:0] sh_h;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;

   // Halfword selection ignores the byte bit of the offset.
   assign half_lo = {addr_lo_i[ALW-1:1], 1'b0};
   assign sh_b    = val_i >> {addr_lo_i, 3'b000};
   assign sh_h    = val_i >> {half_lo, 3'b000};
   assign byte_v  = sh_b[7:0];
   assign half_v  = sh_h[15:0];

   // Pick the extension according to the select code; unknown codes give 0.
   always_comb begin
      ext_o = '0;
      case (sx_op_i)
         WB_SX_BP, WB_SX_IMM, WB_SX_PC: ext_o = val_i;
         WB_SX_UB: ext_o = {{(XLEN-8){1'b0}}, byte_v};
         WB_SX_B:  ext_o = {{(XLEN-8){byte_v[7]}}, byte_v};
         WB_SX_UH: ext_o = {{(XLEN-16){1'b0}}, half_v};
         WB_SX_H:  ext_o = {{(XLEN-16){half_v[15]}}, half_v};
         default:  ext_o = '0;
      endcase
   end

endmodule

// File: rtl/core_wb_q.sv
// Write-back stage with an in-order completion queue. Instructions are held
// in program order until their result is known; load data arrives as in-order
// acks. One entry retires per cycle. An empty queue passes a ready result
// straight to the output registers so ALU ops still write one cycle later.
module core_wb_q
   import core_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int REGW  = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wb_valid_in,
   output logic                         wb_ready_out,
   input  logic                         wb_mux_alu_mem_in,
   input  logic                         wb_we_reg_file_in,
   input  logic [2:0]                   wb_sx_op_in,
   input  logic [$clog2(XLEN/8)-1:0]    wb_addr_lo_in,
   input  logic [REGW-1:0]              wb_rd_in,
   input  logic [XLEN-1:0]              wb_alu_result_in,
   input  logic [XLEN-1:0]              wb_sx_imm_in,
   input  logic [XLEN-1:0]              wb_pc_4_in,
   input  logic                         wb_mem_ack_in,
   input  logic [XLEN-1:0]              wb_mem_data_in,
   output logic                         wb_we_reg_file_out,
   output logic [REGW-1:0]              wb_rd_out,
   output logic [XLEN-1:0]              wb_data_out,
   output logic                         wb_stall_out,
   output logic [(1<<REGW)-1:0]         wb2haz_pend_out,
   output logic                         wb_ack_err_out
);

   localparam int         ALW  = $clog2(XLEN/8);
   localparam int         PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   wb_ctl_t         ctl_q     [DEPTH];
   logic [REGW-1:0] ent_rd_q  [DEPTH];
   logic [ALW-1:0]  ent_lo_q  [DEPTH];
   logic [XLEN-1:0] ent_val_q [DEPTH];

   logic [PW-1:0]   head_q, tail_q;
   logic [PW:0]     count_q;

   logic            we_out_q;
   logic [REGW-1:0] rd_out_q;
   logic [XLEN-1:0] data_out_q;
   logic            err_q;

   logic            accept, in_load;
   logic [XLEN-1:0] in_val;
   logic            ld_hit;
   logic [PW-1:0]   ld_idx, scan_idx;
   logic            ack_old, ack_new, ack_err;
   wb_ctl_t         push_ctl;
   logic [XLEN-1:0] push_val;
   logic            h_valid, h_rdy, h_we;
   logic [2:0]      h_sx;
   logic [REGW-1:0] h_rd;
   logic [ALW-1:0]  h_lo;
   logic [XLEN-1:0] h_val;
   logic [XLEN-1:0] ext_v;
   logic            retire, bypass, push, pop;
   logic [PW-1:0]   pend_idx;
   logic [(1<<REGW)-1:0] pend;

   assign wb_ready_out       = (count_q < FULL);
   assign wb_stall_out       = ~wb_ready_out;
   assign wb_we_reg_file_out = we_out_q;
   assign wb_rd_out          = rd_out_q;
   assign wb_data_out        = data_out_q;
   assign wb_ack_err_out     = err_q;
   assign wb2haz_pend_out    = pend;

   assign accept  = wb_valid_in && wb_ready_out;
   assign in_load = ~wb_mux_alu_mem_in;

   // Find the oldest queued load still waiting for data (lowest offset wins).
   always_comb begin
      ld_hit   = 1'b0;
      ld_idx   = head_q;
      scan_idx = head_q;
      for (int i = DEPTH-1; i >= 0; i--) begin
         scan_idx = head_q + PW'(i);
         if (((PW+1)'(i) < count_q) && ctl_q[scan_idx].is_load && !ctl_q[scan_idx].rdy) begin
            ld_hit = 1'b1;
            ld_idx = scan_idx;
         end
      end
   end

   // An ack goes to a queued load first; only with none waiting can it
   // complete a load being accepted in the same cycle.
   assign ack_old = wb_mem_ack_in && ld_hit;
   assign ack_new = wb_mem_ack_in && !ld_hit && accept && in_load;
   assign ack_err = wb_mem_ack_in && !ld_hit && !ack_new;

   // Build the incoming entry; IMM and PC results are captured here.
   always_comb begin
      in_val = wb_alu_result_in;
      if (wb_sx_op_in == WB_SX_IMM) in_val = wb_sx_imm_in;
      else if (wb_sx_op_in == WB_SX_PC) in_val = wb_pc_4_in;
      push_ctl.we      = wb_we_reg_file_in;
      push_ctl.sx_op   = wb_sx_op_in;
      push_ctl.is_load = in_load;
      push_ctl.rdy     = !in_load || ack_new;
      push_val         = ack_new ? wb_mem_data_in : in_val;
   end

   // Retire candidate: queue head, or the incoming entry when the queue is empty.
   always_comb begin
      h_valid = 1'b0;
      h_rdy   = 1'b0;
      h_we    = 1'b0;
      h_sx    = WB_SX_BP;
      h_rd    = '0;
      h_lo    = '0;
      h_val   = '0;
      if (count_q != '0) begin
         h_valid = 1'b1;
         h_we    = ctl_q[head_q].we;
         h_sx    = ctl_q[head_q].sx_op;
         h_rd    = ent_rd_q[head_q];
         h_lo    = ent_lo_q[head_q];
         h_val   = ent_val_q[head_q];
         h_rdy   = ctl_q[head_q].rdy;
         if (ack_old && (ld_idx == head_q)) begin
            h_rdy = 1'b1;
            h_val = wb_mem_data_in;
         end
      end else begin
         h_valid = accept;
         h_we    = wb_we_reg_file_in;
         h_sx    = wb_sx_op_in;
         h_rd    = wb_rd_in;
         h_lo    = wb_addr_lo_in;
         h_val   = push_val;
         h_rdy   = push_ctl.rdy;
      end
   end

   assign retire = h_valid && h_rdy;
   assign bypass = retire && (count_q == '0);
   assign push   = accept && !bypass;
   assign pop    = retire && (count_q != '0);

   core_wb_ext #(.XLEN(XLEN)) u_ext (
      .val_i     (h_val),
      .sx_op_i   (h_sx),
      .addr_lo_i (h_lo),
      .ext_o     (ext_v)
   );

   // Hazard view: every queued entry that will still write a nonzero rd.
   always_comb begin
      pend     = '0;
      pend_idx = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         pend_idx = head_q + PW'(i);
         if (((PW+1)'(i) < count_q) && ctl_q[pend_idx].we && (ent_rd_q[pend_idx] != '0))
            pend[ent_rd_q[pend_idx]] = 1'b1;
      end
   end

   // Queue storage, pointers, count and registered write-back outputs.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         we_out_q   <= 1'b0;
         rd_out_q   <= '0;
         data_out_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ctl_q[i] <= '0;
      end else begin
         if (push) begin
            ctl_q[tail_q]     <= push_ctl;
            ent_rd_q[tail_q]  <= wb_rd_in;
            ent_lo_q[tail_q]  <= wb_addr_lo_in;
            ent_val_q[tail_q] <= push_val;
            tail_q            <= tail_q + PW'(1);
         end
         if (ack_old) begin
            ctl_q[ld_idx].rdy <= 1'b1;
            ent_val_q[ld_idx] <= wb_mem_data_in;
         end
         if (pop) head_q <= head_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
         we_out_q <= retire && h_we;
         if (retire) begin
            rd_out_q   <= h_rd;
            data_out_q <= ext_v;
         end
         err_q <= ack_err;
      end
   end

endmodule

// File: tb/tb_core_wb_q.sv
// Bench for core_wb_q: expected writes go into a scoreboard when stimulus is
// driven; a negedge monitor pops and compares each register-file write.
module tb_core_wb_q;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid_in, wb_ready_out, wb_mux_alu_mem_in, wb_we_reg_file_in;
   logic [2:0]  wb_sx_op_in;
   logic [1:0]  wb_addr_lo_in;
   logic [4:0]  wb_rd_in;
   logic [31:0] wb_alu_result_in, wb_sx_imm_in, wb_pc_4_in;
   logic        wb_mem_ack_in;
   logic [31:0] wb_mem_data_in;
   logic        wb_we_reg_file_out;
   logic [4:0]  wb_rd_out;
   logic [31:0] wb_data_out;
   logic        wb_stall_out;
   logic [31:0] wb2haz_pend_out;
   logic        wb_ack_err_out;

   always #5 clk = ~clk;

   core_wb_q #(.XLEN(32), .DEPTH(4), .REGW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid_in(wb_valid_in), .wb_ready_out(wb_ready_out),
      .wb_mux_alu_mem_in(wb_mux_alu_mem_in), .wb_we_reg_file_in(wb_we_reg_file_in),
      .wb_sx_op_in(wb_sx_op_in), .wb_addr_lo_in(wb_addr_lo_in), .wb_rd_in(wb_rd_in),
      .wb_alu_result_in(wb_alu_result_in), .wb_sx_imm_in(wb_sx_imm_in), .wb_pc_4_in(wb_pc_4_in),
      .wb_mem_ack_in(wb_mem_ack_in), .wb_mem_data_in(wb_mem_data_in),
      .wb_we_reg_file_out(wb_we_reg_file_out), .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out),
      .wb_stall_out(wb_stall_out), .wb2haz_pend_out(wb2haz_pend_out), .wb_ack_err_out(wb_ack_err_out)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      sb.push_back(e);
   endtask

   // One cycle of stimulus; returns 1 time unit after the edge it was sampled on.
   task automatic drv(input logic v, input logic alu, input logic [4:0] rd, input logic we,
                      input logic [2:0] sx, input logic [1:0] lo, input logic [31:0] res,
                      input logic ack, input logic [31:0] ad);
      wb_valid_in       = v;
      wb_mux_alu_mem_in = alu;
      wb_rd_in          = rd;
      wb_we_reg_file_in = we;
      wb_sx_op_in       = sx;
      wb_addr_lo_in     = lo;
      wb_alu_result_in  = res;
      wb_mem_ack_in     = ack;
      wb_mem_data_in    = ad;
      @(posedge clk);
      #1;
      wb_valid_in   = 1'b0;
      wb_mem_ack_in = 1'b0;
   endtask

   task automatic idle();
      drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b0, 32'd0);
   endtask

   // Every register-file write must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst_n && wb_we_reg_file_out) begin
         if (sb.size() == 0) begin
            chk("unexp_wr", {63'd0, wb_we_reg_file_out}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("wr_rd", {59'd0, wb_rd_out}, {59'd0, mon_e.rd});
            chk("wr_data", {32'd0, wb_data_out}, {32'd0, mon_e.data});
         end
      end
   end

   logic [2:0]  c_sx   [8] = '{WB_SX_B, WB_SX_UB, WB_SX_H, WB_SX_UH, WB_SX_H, WB_SX_B, WB_SX_BP, WB_SX_UB};
   logic [1:0]  c_lo   [8] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0};
   logic [31:0] c_dat  [8] = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h8000_0000,
                               32'h8000_0000, 32'h0000_8000, 32'hCAFE_F00D, 32'h1234_56FF};
   logic [31:0] c_exp  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0080, 32'h0000_8000,
                               32'hFFFF_8000, 32'hFFFF_FF80, 32'hCAFE_F00D, 32'h0000_00FF};
   logic        c_same [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      rst_n             = 1'b1;
      wb_valid_in       = 1'b0;
      wb_mux_alu_mem_in = 1'b1;
      wb_we_reg_file_in = 1'b0;
      wb_sx_op_in       = WB_SX_BP;
      wb_addr_lo_in     = 2'd0;
      wb_rd_in          = 5'd0;
      wb_alu_result_in  = 32'd0;
      wb_sx_imm_in      = 32'hDEAD_0001;
      wb_pc_4_in        = 32'h0000_1004;
      wb_mem_ack_in     = 1'b0;
      wb_mem_data_in    = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;

      chk("rst_we", {63'd0, wb_we_reg_file_out}, 64'd0);
      chk("rst_rd", {59'd0, wb_rd_out}, 64'd0);
      chk("rst_data", {32'd0, wb_data_out}, 64'd0);
      chk("rst_ready", {63'd0, wb_ready_out}, 64'd1);
      chk("rst_stall", {63'd0, wb_stall_out}, 64'd0);
      chk("rst_pend", {32'd0, wb2haz_pend_out}, 64'd0);
      chk("rst_err", {63'd0, wb_ack_err_out}, 64'd0);

      // ALU op into empty queue writes on the next cycle
      push_exp(5'd3, 32'h1234_5678);
      drv(1'b1, 1'b1, 5'd3, 1'b1, WB_SX_BP, 2'd0, 32'h1234_5678, 1'b0, 32'd0);
      chk("alu_lat_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      idle();
      chk("alu_we_drop", {63'd0, wb_we_reg_file_out}, 64'd0);

      // IMM, PC and an undefined select code
      push_exp(5'd9, 32'hDEAD_0001);
      drv(1'b1, 1'b1, 5'd9, 1'b1, WB_SX_IMM, 2'd0, 32'h111, 1'b0, 32'd0);
      chk("imm_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      push_exp(5'd10, 32'h0000_1004);
      drv(1'b1, 1'b1, 5'd10, 1'b1, WB_SX_PC, 2'd0, 32'h222, 1'b0, 32'd0);
      chk("pc_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      push_exp(5'd11, 32'd0);
      drv(1'b1, 1'b1, 5'd11, 1'b1, 3'd7, 2'd0, 32'h1234, 1'b0, 32'd0);
      chk("undef_we", {63'd0, wb_we_reg_file_out}, 64'd1);

      // Load align/extend cases, some with the ack in the accept cycle
      for (int k = 0; k < 8; k++) begin
         push_exp(5'd20, c_exp[k]);
         if (c_same[k]) begin
            drv(1'b1, 1'b0, 5'd20, 1'b1, c_sx[k], c_lo[k], 32'd0, 1'b1, c_dat[k]);
         end else begin
            drv(1'b1, 1'b0, 5'd20, 1'b1, c_sx[k], c_lo[k], 32'd0, 1'b0, 32'd0);
            chk("ld_wait_we", {63'd0, wb_we_reg_file_out}, 64'd0);
            drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b1, c_dat[k]);
         end
         chk("ld_ack_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      end
      idle();

      // Load followed by two ALU ops; younger ALUs wait behind the load
      push_exp(5'd5, 32'h0000_0055);
      push_exp(5'd6, 32'h0000_0066);
      push_exp(5'd7, 32'h0000_0077);
      drv(1'b1, 1'b0, 5'd5, 1'b1, WB_SX_BP, 2'd0, 32'd0, 1'b0, 32'd0);
      drv(1'b1, 1'b1, 5'd6, 1'b1, WB_SX_BP, 2'd0, 32'h66, 1'b0, 32'd0);
      drv(1'b1, 1'b1, 5'd7, 1'b1, WB_SX_BP, 2'd0, 32'h77, 1'b0, 32'd0);
      idle();
      idle();
      idle();
      chk("ord_pend", {32'd0, wb2haz_pend_out}, 64'h0000_00E0);
      chk("ord_hold_we", {63'd0, wb_we_reg_file_out}, 64'd0);
      drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b1, 32'h55);
      chk("ord_c7_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      idle();
      chk("ord_c8_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      idle();
      chk("ord_c9_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      idle();
      chk("ord_done_we", {63'd0, wb_we_reg_file_out}, 64'd0);
      chk("ord_done_pend", {32'd0, wb2haz_pend_out}, 64'd0);

      // Fill the queue with loads
      for (int k = 0; k < 4; k++) begin
         push_exp(5'(8 + k), 32'h100 + 32'(k));
         drv(1'b1, 1'b0, 5'(8 + k), 1'b1, WB_SX_BP, 2'd0, 32'd0, 1'b0, 32'd0);
      end
      chk("full_ready", {63'd0, wb_ready_out}, 64'd0);
      chk("full_stall", {63'd0, wb_stall_out}, 64'd1);
      drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b1, 32'h100);
      chk("drain_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      chk("drain_ready", {63'd0, wb_ready_out}, 64'd1);
      chk("drain_stall", {63'd0, wb_stall_out}, 64'd0);
      for (int k = 1; k < 4; k++)
         drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b1, 32'h100 + 32'(k));
      idle();

      // Ack with nothing outstanding
      drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b1, 32'hBEEF);
      chk("err_pulse", {63'd0, wb_ack_err_out}, 64'd1);
      chk("err_no_we", {63'd0, wb_we_reg_file_out}, 64'd0);
      idle();
      chk("err_clear", {63'd0, wb_ack_err_out}, 64'd0);

      // Reset with two loads pending discards them
      drv(1'b1, 1'b0, 5'd13, 1'b1, WB_SX_BP, 2'd0, 32'd0, 1'b0, 32'd0);
      drv(1'b1, 1'b0, 5'd14, 1'b1, WB_SX_BP, 2'd0, 32'd0, 1'b0, 32'd0);
      chk("pre_rst_pend", {32'd0, wb2haz_pend_out}, 64'h0000_6000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      chk("rst2_pend", {32'd0, wb2haz_pend_out}, 64'd0);
      chk("rst2_ready", {63'd0, wb_ready_out}, 64'd1);
      chk("rst2_data", {32'd0, wb_data_out}, 64'd0);
      drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b1, 32'h77);
      chk("rst2_late_err", {63'd0, wb_ack_err_out}, 64'd1);
      chk("rst2_no_we", {63'd0, wb_we_reg_file_out}, 64'd0);

      // rd=0 still writes but never shows as pending
      push_exp(5'd12, 32'h0000_0BAD);
      push_exp(5'd0, 32'h0000_0ABC);
      drv(1'b1, 1'b0, 5'd12, 1'b1, WB_SX_BP, 2'd0, 32'd0, 1'b0, 32'd0);
      drv(1'b1, 1'b1, 5'd0, 1'b1, WB_SX_BP, 2'd0, 32'hABC, 1'b0, 32'd0);
      chk("rd0_pend", {32'd0, wb2haz_pend_out}, 64'h0000_1000);
      drv(1'b0, 1'b1, 5'd0, 1'b0, WB_SX_BP, 2'd0, 32'd0, 1'b1, 32'hBAD);
      chk("rd0_ld_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      idle();
      chk("rd0_we", {63'd0, wb_we_reg_file_out}, 64'd1);
      chk("rd0_pend_end", {32'd0, wb2haz_pend_out}, 64'd0);

      repeat (3) idle();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
